video_acc_inst_arbiter: RTL

VIDEO_ACC_INST_ARBITER -- requirements
Module: video_acc_inst_arbiter

---
 rtl/video_acc_inst_arbiter_if.sv | 33 +++
 rtl/video_acc_inst_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/video_acc_inst_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : video_acc_inst_arbiter_if
// Brief    : Requester-side and FIFO-side bus bundle for the instruction arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface video_acc_inst_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int INST_WIDTH = 32
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*INST_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        out_valid;
  logic [INST_WIDTH-1:0]       out_data;
  logic                        out_ready;
  logic [ID_W-1:0]             grant_id;
  logic                        locked;
  logic [15:0]                 inst_count;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, grant_id, locked, inst_count
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, grant_id, locked, inst_count
  );
endinterface
`default_nettype wire

// File: rtl/video_acc_inst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : video_acc_inst_arbiter
// Brief    : Round-robin instruction arbiter that keeps multi-word LOAD_FULL
//            instructions contiguous toward the instruction FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module video_acc_inst_arbiter #(
  parameter int N_REQ      = 4,
  parameter int INST_WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  video_acc_inst_arbiter_if.slave bus
);
  localparam int               ID_W           = $clog2(N_REQ);
  localparam logic [5:0]       C_OP_LOAD_FULL = 6'h02;
  localparam logic [ID_W-1:0]  C_LAST_ID      = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]    C_N_REQ        = (ID_W+1)'(N_REQ);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr,   w_ptr_nxt;
  logic [ID_W-1:0]       r_owner,    w_owner_nxt;
  logic [1:0]            r_remaining, w_rem_nxt;
  logic [15:0]           r_inst_count, w_cnt_nxt;
  logic                  r_out_valid;
  logic [INST_WIDTH-1:0] r_out_data;
  logic [ID_W-1:0]       r_grant_id;

  logic [INST_WIDTH-1:0] w_words [N_REQ];
  logic                  w_slot_free;
  logic                  w_found;
  logic [ID_W-1:0]       w_winner;
  logic [ID_W:0]         w_sum;
  logic [ID_W-1:0]       w_idx;
  logic [N_REQ-1:0]      w_ready;
  logic                  w_accept;
  logic [ID_W-1:0]       w_sel;
  logic [INST_WIDTH-1:0] w_word;

  function automatic logic [ID_W-1:0] f_next_id(input logic [ID_W-1:0] id);
    return (id == C_LAST_ID) ? '0 : id + ID_W'(1);
  endfunction

  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_words[g] = bus.req_data[g*INST_WIDTH +: INST_WIDTH];
    end
  endgenerate

  assign w_slot_free = !r_out_valid || bus.out_ready;

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= C_N_REQ) begin
        w_sum = w_sum - C_N_REQ;
      end
      w_idx = w_sum[ID_W-1:0];
      if (bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_rr_ptr;
    w_owner_nxt = r_owner;
    w_rem_nxt   = r_remaining;
    w_cnt_nxt   = r_inst_count;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_sel       = r_owner;
    case (r_state)
      S_IDLE: begin
        if (w_slot_free && w_found) begin
          w_ready[w_winner] = 1'b1;
          w_accept          = 1'b1;
          w_sel             = w_winner;
          if (w_words[w_winner][5:0] == C_OP_LOAD_FULL) begin
            w_state_nxt = S_LOCKED;
            w_owner_nxt = w_winner;
            w_rem_nxt   = 2'd2;
          end else begin
            w_ptr_nxt = f_next_id(w_winner);
            w_cnt_nxt = r_inst_count + 16'd1;
          end
        end
      end
      S_LOCKED: begin
        // Continuation words are passed through without opcode decode.
        if (w_slot_free) begin
          w_ready[r_owner] = 1'b1;
          if (bus.req_valid[r_owner]) begin
            w_accept = 1'b1;
            if (r_remaining == 2'd1) begin
              w_state_nxt = S_IDLE;
              w_ptr_nxt   = f_next_id(r_owner);
              w_cnt_nxt   = r_inst_count + 16'd1;
              w_rem_nxt   = 2'd0;
            end else begin
              w_rem_nxt = r_remaining - 2'd1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_word = w_words[w_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_remaining  <= 2'd0;
      r_inst_count <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_ptr_nxt;
      r_owner      <= w_owner_nxt;
      r_remaining  <= w_rem_nxt;
      r_inst_count <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_grant_id  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_grant_id  <= w_sel;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.req_ready  = rst ? '0 : w_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.grant_id   = r_grant_id;
  assign bus.locked     = (r_state == S_LOCKED);
  assign bus.inst_count = r_inst_count;
endmodule
`default_nettype wire
